// File: rtl/simplebus_leader_bridge_if.sv
// simplebus interconnect: one leader, any number of followers sharing a tri-stated
// data/dataValid pair. Each side supplies a value plus an enable; the shared nets
// float whenever nobody drives them.
interface simplebus;
  logic       start;
  logic       read;
  logic [7:0] address;

  logic       leader_drive;
  logic [7:0] leader_data;
  logic       follower_drive;
  logic [7:0] follower_data;
  logic       follower_valid;

  wire  [7:0] data;
  wire        dataValid;

  // The leader only drives during its write data beat, so it never contends with a follower.
  assign data      = leader_drive ? leader_data :
                     (follower_drive ? follower_data : 8'bzzzz_zzzz);
  assign dataValid = leader_drive ? 1'b1 :
                     (follower_drive ? follower_valid : 1'bz);

  modport leader (
    output start, read, address, leader_drive, leader_data,
    inout  data, dataValid
  );

  modport follower (
    input  start, read, address,
    output follower_drive, follower_data, follower_valid,
    inout  data, dataValid
  );
endinterface

// File: rtl/simplebus_leader_bridge.sv
// Synthesizable simplebus leader: turns a single-beat host request into the
// three-byte address phase plus a write beat or a timed read wait.
module simplebus_leader_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  simplebus.leader    bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDR_UP    = 3'd1,
    ADDR_MID   = 3'd2,
    ADDR_LO    = 3'd3,
    READ_WAIT  = 3'd4,
    WRITE_DATA = 3'd5
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic        read_lat;
  logic [23:0] addr_lat;
  logic [7:0]  wdata_lat;
  logic [7:0]  wait_cnt;
  logic        accept;
  logic        timed_out;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign timed_out = (wait_cnt == LAST_WAIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus Moore decode of every bus output from the registered state.
  always_comb begin
    state_next       = state;
    bus.start        = 1'b0;
    bus.read         = 1'b0;
    bus.address      = 8'h00;
    bus.leader_drive = 1'b0;
    bus.leader_data  = 8'h00;
    case (state)
      IDLE: begin
        if (accept) state_next = ADDR_UP;
        else        state_next = IDLE;
      end
      ADDR_UP: begin
        bus.start   = 1'b1;
        bus.address = addr_lat[23:16];
        state_next  = ADDR_MID;
      end
      ADDR_MID: begin
        bus.address = addr_lat[15:8];
        state_next  = ADDR_LO;
      end
      ADDR_LO: begin
        bus.address = addr_lat[7:0];
        bus.read    = read_lat;
        if (read_lat) state_next = READ_WAIT;
        else          state_next = WRITE_DATA;
      end
      READ_WAIT: begin
        if (bus.dataValid || timed_out) state_next = IDLE;
        else                            state_next = READ_WAIT;
      end
      WRITE_DATA: begin
        bus.leader_drive = 1'b1;
        bus.leader_data  = wdata_lat;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_lat  <= 1'b0;
      addr_lat  <= 24'h00_0000;
      wdata_lat <= 8'h00;
    end else if (accept) begin
      read_lat  <= req_read;
      addr_lat  <= req_addr;
      wdata_lat <= req_wdata;
    end
  end

  // Wait counter is zeroed while the last address byte is on the bus, then saturates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'h00;
    end else if (state == ADDR_LO) begin
      wait_cnt <= 8'h00;
    end else if (state == READ_WAIT && wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'h01;
    end
  end

  // A dataValid seen on the timeout edge takes priority over the timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == WRITE_DATA) begin
        rsp_valid <= 1'b1;
        rsp_error <= 1'b0;
      end else if (state == READ_WAIT) begin
        if (bus.dataValid) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= bus.data;
          rsp_error <= 1'b0;
        end else if (timed_out) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= 8'hFF;
          rsp_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_simplebus_leader_bridge.sv
// Directed bench for simplebus_leader_bridge: a behavioural follower answering
// followers 1 and 2 with a programmable delay, a vector table and corner sequences.
module tb_simplebus_leader_bridge;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic [23:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;

  int checks;
  int errors;
  int f_delay;

  simplebus bus ();

  simplebus_leader_bridge #(.TIMEOUT(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_read  (req_read),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Follower model: responds to follower ids 1 and 2 only.
  logic [7:0] mem [0:1023];
  logic [1:0] f_ph;
  logic [7:0] f_id, f_mid, f_lo;
  logic       f_pend_w, f_pend_r;
  int         f_cnt;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      f_ph               <= 2'd0;
      f_id               <= 8'h00;
      f_mid              <= 8'h00;
      f_lo               <= 8'h00;
      f_pend_w           <= 1'b0;
      f_pend_r           <= 1'b0;
      f_cnt              <= 0;
      bus.follower_drive <= 1'b0;
      bus.follower_valid <= 1'b0;
      bus.follower_data  <= 8'h00;
    end else begin
      bus.follower_drive <= 1'b0;
      bus.follower_valid <= 1'b0;
      if (bus.start) begin
        f_id <= bus.address;
        f_ph <= 2'd1;
      end else if (f_ph == 2'd1) begin
        f_mid <= bus.address;
        f_ph  <= 2'd2;
      end else if (f_ph == 2'd2) begin
        f_lo <= bus.address;
        f_ph <= 2'd0;
        if (f_id == 8'h01 || f_id == 8'h02) begin
          if (bus.read) begin
            if (f_delay == 1) begin
              bus.follower_drive <= 1'b1;
              bus.follower_valid <= 1'b1;
              bus.follower_data  <= mem[{f_id[1:0], f_mid[3:0], bus.address[3:0]}];
            end else begin
              f_pend_r <= 1'b1;
              f_cnt    <= 2;
            end
          end else begin
            f_pend_w <= 1'b1;
          end
        end
      end
      if (f_pend_w && bus.dataValid === 1'b1) begin
        mem[{f_id[1:0], f_mid[3:0], f_lo[3:0]}] <= bus.data;
        f_pend_w <= 1'b0;
      end
      if (f_pend_r) begin
        if (f_cnt == f_delay) begin
          bus.follower_drive <= 1'b1;
          bus.follower_valid <= 1'b1;
          bus.follower_data  <= mem[{f_id[1:0], f_mid[3:0], f_lo[3:0]}];
          f_pend_r           <= 1'b0;
        end else begin
          f_cnt <= f_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request; lat is the cycle index (0 = cycle after acceptance) of rsp_valid, -1 if none.
  task automatic run_req(input logic rd, input logic [23:0] a, input logic [7:0] wd,
                         input int dly, output int lat, output logic [7:0] rdata,
                         output logic err);
    @(negedge clock);
    f_delay   = dly;
    req_valid = 1'b1;
    req_read  = rd;
    req_addr  = a;
    req_wdata = wd;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    lat   = -1;
    rdata = 8'h00;
    err   = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (rsp_valid) begin
        lat   = k;
        rdata = rsp_rdata;
        err   = rsp_error;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    chk("rsp_single_pulse", {31'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic        rd;
    logic [23:0] addr;
    logic [7:0]  wdata;
    int          dly;
    int          lat;
    logic [7:0]  rdata;
    logic        err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int         lat;
    logic [7:0] rdata;
    logic       err;
    int         seen;
    int         xbad;

    vecs[0] = '{1'b0, 24'h020500, 8'h3C, 2,  4,  8'h00, 1'b0};
    vecs[1] = '{1'b1, 24'h010406, 8'h00, 2,  5,  8'hDC, 1'b0};
    vecs[2] = '{1'b1, 24'h010406, 8'h00, 9,  12, 8'hDC, 1'b0};
    vecs[3] = '{1'b1, 24'h020500, 8'h00, 4,  7,  8'h3C, 1'b0};
    vecs[4] = '{1'b1, 24'h050000, 8'h00, 2,  19, 8'hFF, 1'b1};
    vecs[5] = '{1'b1, 24'h010406, 8'h00, 3,  6,  8'hDC, 1'b0};
    vecs[6] = '{1'b0, 24'h0300FF, 8'h77, 2,  4,  8'h00, 1'b0};
    vecs[7] = '{1'b1, 24'h010406, 8'h00, 16, 19, 8'hDC, 1'b0};
    vecs[8] = '{1'b1, 24'h010406, 8'h00, 17, 19, 8'hFF, 1'b1};
    vecs[9] = '{1'b1, 24'h010406, 8'h00, 2,  5,  8'hDC, 1'b0};

    checks    = 0;
    errors    = 0;
    f_delay   = 2;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_read  = 1'b0;
    req_addr  = 24'h000000;
    req_wdata = 8'h00;
    #1 reset = 1'b1;
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_start",     {31'd0, bus.start}, 32'd0);
    chk("rst_address",   {24'd0, bus.address}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Write 01:0406 = DC with a cycle-by-cycle bus trace.
    f_delay   = 2;
    req_valid = 1'b1;
    req_read  = 1'b0;
    req_addr  = 24'h010406;
    req_wdata = 8'hDC;
    @(negedge clock);
    req_valid = 1'b0;
    chk("tr0_start", {31'd0, bus.start}, 32'd1);
    chk("tr0_addr",  {24'd0, bus.address}, 32'h01);
    @(negedge clock);
    chk("tr1_start", {31'd0, bus.start}, 32'd0);
    chk("tr1_addr",  {24'd0, bus.address}, 32'h04);
    @(negedge clock);
    chk("tr2_addr",  {24'd0, bus.address}, 32'h06);
    chk("tr2_read",  {31'd0, bus.read}, 32'd0);
    chk("tr2_dv_released", {31'd0, bus.dataValid === 1'b1}, 32'd0);
    @(negedge clock);
    chk("tr3_dv",    {31'd0, bus.dataValid === 1'b1}, 32'd1);
    chk("tr3_data",  {24'd0, bus.data}, 32'hDC);
    chk("tr3_addr",  {24'd0, bus.address}, 32'h00);
    chk("tr3_rsp",   {31'd0, rsp_valid}, 32'd0);
    @(negedge clock);
    chk("tr4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("tr4_rsp_error", {31'd0, rsp_error}, 32'd0);
    chk("tr4_dv_released", {31'd0, bus.dataValid === 1'b1}, 32'd0);
    @(negedge clock);
    chk("tr5_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].dly, lat, rdata, err);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_error", i), {31'd0, err}, {31'd0, vecs[i].err});
      if (vecs[i].rd) chk($sformatf("vec%0d_rdata", i), {24'd0, rdata}, {24'd0, vecs[i].rdata});
    end

    // Back-to-back: write 02:0407 = AB then read it with req_valid held high.
    @(negedge clock);
    f_delay   = 3;
    req_valid = 1'b1;
    req_read  = 1'b0;
    req_addr  = 24'h020407;
    req_wdata = 8'hAB;
    @(negedge clock);
    req_read = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("b2b_busy_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("b2b_wr_rsp",   {31'd0, rsp_valid}, 32'd1);
    chk("b2b_ready_on_rsp", {31'd0, req_ready}, 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
    chk("b2b_rd_start", {31'd0, bus.start}, 32'd1);
    chk("b2b_rd_addr",  {24'd0, bus.address}, 32'h02);
    @(negedge clock);
    @(negedge clock);
    chk("b2b_rd_read",  {31'd0, bus.read}, 32'd1);
    chk("b2b_rd_lo",    {24'd0, bus.address}, 32'h07);
    lat   = -1;
    rdata = 8'h00;
    xbad  = 0;
    for (int k = 3; k < 40; k++) begin
      @(negedge clock);
      for (int b = 0; b < 8; b++) if (bus.data[b] === 1'bx) xbad++;
      if (rsp_valid) begin
        lat   = k;
        rdata = rsp_rdata;
        break;
      end
    end
    chk("b2b_no_x", xbad, 0);
    chk("b2b_rd_latency", lat, 6);
    chk("b2b_rd_rdata", {24'd0, rdata}, 32'hAB);

    // Reset during ADDR_MID of a write to 01:0406 must abort it cleanly.
    @(negedge clock);
    f_delay   = 2;
    req_valid = 1'b1;
    req_read  = 1'b0;
    req_addr  = 24'h010406;
    req_wdata = 8'h55;
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    chk("abort_mid_addr", {24'd0, bus.address}, 32'h04);
    reset = 1'b1;
    #1;
    chk("abort_addr",  {24'd0, bus.address}, 32'h00);
    chk("abort_start", {31'd0, bus.start}, 32'd0);
    chk("abort_read",  {31'd0, bus.read}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd0);
    chk("abort_dv",    {31'd0, bus.dataValid === 1'b1}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", seen, 0);
    run_req(1'b1, 24'h010406, 8'h00, 2, lat, rdata, err);
    chk("abort_rd_latency", lat, 5);
    chk("abort_rd_rdata", {24'd0, rdata}, 32'hDC);
    chk("abort_rd_error", {31'd0, err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
